alu_share_ctrl: RTL and testbench
=================================

Name: alu_share_ctrl

Overview:
- Round-robin controller that shares one combinational 32-bit ALU (ADD/SUB/SLT/AND/OR, flags Z/N/V) among NREQ requesters.
- Accepts one operation at a time over a valid/ready handshake and drives registered operands and control into the ALU.
- Holds the operands stable for a settle window, then captures result and flags into a response register returned over a second valid/ready handshake.
- Sits between issuing units (sequencers, address calc) and the single shared ALU instance.

Parameters:
NREQ, 4, number of requesters (2..8)
IDW, 2, width of rsp_id; must satisfy 2**IDW >= NREQ
ALU_WAIT, 2, cycles operands are held on the ALU before capture (>=1)

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-high reset
req_valid  in  NREQ  per-requester request valid
req_ready  out  NREQ  per-requester accept, one-hot or zero
req_a  in  NREQ*32  operand A, requester i at [32i+31:32i]
req_b  in  NREQ*32  operand B, same packing
req_gin  in  NREQ*3  ALU control code, requester i at [3i+2:3i]
alu_a  out  32  registered operand A to ALU
alu_b  out  32  registered operand B to ALU
alu_gin  out  3  registered ALU control
alu_sum  in  32  ALU result
alu_zout  in  1  ALU zero flag
alu_n  in  1  ALU negative flag
alu_v  in  1  ALU overflow flag
rsp_valid  out  1  response valid
rsp_ready  in  1  response consumed
rsp_id  out  IDW  index of the requester that owns the response
rsp_sum  out  32  captured result
rsp_z  out  1  captured zero flag
rsp_n  out  1  captured negative flag
rsp_v  out  1  captured overflow flag
rsp_err  out  1  1 = illegal gin code, no ALU operation performed
busy  out  1  state != IDLE

Behaviour:
- Reset (asynchronous, active-high) forces:
  - state IDLE, priority pointer 0, settle counter 0.
  - All outputs to 0 (alu_gin = 3'b000).
  - req_ready = 0 while reset is asserted.
- Reset mid-operation aborts the in-flight operation silently: no response is produced.
- States: IDLE, SETTLE, RESP. Only one operation is in flight at a time.
- IDLE:
  - req_ready is combinational: one-hot for the first asserted req_valid at or after the pointer, scanning upward with wrap from NREQ-1 to 0.
  - On accept (valid & ready), latch the winner's a/b/gin into alu_a/alu_b/alu_gin, latch the winner index into rsp_id, and set pointer = (winner+1) mod NREQ.
  - If gin is legal (010, 110, 111, 000, 001): load counter = ALU_WAIT-1 and go to SETTLE.
  - If gin is illegal: go directly to RESP with rsp_sum = 0, rsp_z = rsp_n = rsp_v = 0, rsp_err = 1. alu_* stays latched but is unused.
- SETTLE:
  - req_ready = 0; decrement the counter each cycle.
  - In the cycle the counter is 0, capture alu_sum/alu_zout/alu_n/alu_v into rsp_*, set rsp_err = 0 and rsp_valid = 1, and go to RESP.
- RESP:
  - rsp_* are held stable while rsp_valid = 1 and rsp_ready = 0.
  - On rsp_ready, clear rsp_valid and go to IDLE. No new accept in that same cycle.
- Latency, with the accept edge as cycle 0:
  - Legal op: rsp_valid rises after edge ALU_WAIT.
  - Illegal op: rsp_valid rises after edge 1.
  - Minimum turnaround per operation: ALU_WAIT+2 cycles.
- alu_* hold their last value outside SETTLE; there is no combinational path from req_* to alu_*.
- Requester deasserting req_valid before acceptance has no effect on the pointer. A requester that holds req_valid is served within NREQ grants.
- Flags are passed through unmodified; the controller does not recompute Z/N/V.

Decomposition:
- Shared package/header:
  - gin encodings GIN_ADD = 3'b010, GIN_SUB = 3'b110, GIN_SLT = 3'b111, GIN_AND = 3'b000, GIN_OR = 3'b001.
  - State encodings IDLE/SETTLE/RESP.
  - Legal-gin check function.
- One natural sub-module: rr_pick. Combinational round-robin pick from req_valid and pointer, producing a one-hot grant plus its index.
- The ALU itself is instantiated outside this block.

Test Plan:
- Single ADD: req 0, a = 5, b = 7, gin 010, ALU_WAIT = 2 -> accept at edge 0; rsp_valid after edge 2; rsp_sum = 12, z = 0, id = 0, err = 0.
- SUB to zero: req 2, a = b = 0x1234 -> rsp_sum = 0, rsp_z = 1, rsp_id = 2.
- Round-robin: all 4 requesters hold valid, rsp_ready tied high.
  - Grant order 0, 1, 2, 3, 0.
  - Each grant is spaced ALU_WAIT+2 cycles apart.
  - Only one req_ready is high at any time.
- Illegal gin 3'b011 on req 1 -> rsp_valid after edge 1; rsp_err = 1, rsp_sum = 0; no SETTLE state entered.
- Backpressure: hold rsp_ready low 5 cycles after rsp_valid -> rsp_* stable; req_ready stays 0 for all requesters; release -> IDLE, next grant one cycle later.
- Reset mid-SETTLE: assert reset during SETTLE -> all outputs 0 immediately, no rsp_valid; after release, requester 0 is served first.

Source files
------------

// File: rtl/alu_share_ctrl_pkg.sv
// Shared definitions for the shared-ALU controller: ALU control codes,
// controller state encodings and the legal-code check.
package alu_share_ctrl_pkg;

  localparam logic [2:0] GIN_ADD = 3'b010;
  localparam logic [2:0] GIN_SUB = 3'b110;
  localparam logic [2:0] GIN_SLT = 3'b111;
  localparam logic [2:0] GIN_AND = 3'b000;
  localparam logic [2:0] GIN_OR  = 3'b001;

  localparam logic [1:0] ST_IDLE   = 2'b00;
  localparam logic [1:0] ST_SETTLE = 2'b01;
  localparam logic [1:0] ST_RESP   = 2'b10;

  function automatic logic gin_legal(input logic [2:0] gin);
    case (gin)
      GIN_ADD, GIN_SUB, GIN_SLT, GIN_AND, GIN_OR: gin_legal = 1'b1;
      default:                                    gin_legal = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/alu_share_ctrl_rr_pick.sv
// Combinational round-robin pick: first asserted valid at or after the
// pointer, scanning upward with wrap. Produces a one-hot grant and its index.
module rr_pick #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic [NREQ-1:0] valid_i,
  input  logic [IDW-1:0]  ptr_i,
  output logic [NREQ-1:0] grant_o,
  output logic [IDW-1:0]  idx_o,
  output logic            any_o
);

  always_comb begin
    int j;
    j       = 0;
    grant_o = '0;
    idx_o   = '0;
    any_o   = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      j = (int'(ptr_i) + k) % NREQ;
      if (!any_o && valid_i[j]) begin
        any_o      = 1'b1;
        grant_o[j] = 1'b1;
        idx_o      = IDW'(j);
      end
    end
  end

endmodule

// File: rtl/alu_share_ctrl.sv
// Round-robin controller sharing one combinational ALU among NREQ requesters:
// accept one op, hold registered operands for ALU_WAIT cycles, return result.
module alu_share_ctrl
  import alu_share_ctrl_pkg::*;
#(
  parameter int NREQ     = 4,
  parameter int IDW      = 2,
  parameter int ALU_WAIT = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NREQ-1:0]     req_valid,
  output logic [NREQ-1:0]     req_ready,
  input  logic [NREQ*32-1:0]  req_a,
  input  logic [NREQ*32-1:0]  req_b,
  input  logic [NREQ*3-1:0]   req_gin,
  output logic [31:0]         alu_a,
  output logic [31:0]         alu_b,
  output logic [2:0]          alu_gin,
  input  logic [31:0]         alu_sum,
  input  logic                alu_zout,
  input  logic                alu_n,
  input  logic                alu_v,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [IDW-1:0]      rsp_id,
  output logic [31:0]         rsp_sum,
  output logic                rsp_z,
  output logic                rsp_n,
  output logic                rsp_v,
  output logic                rsp_err,
  output logic                busy
);

  localparam int CW = (ALU_WAIT > 1) ? $clog2(ALU_WAIT) : 1;

  logic [1:0]      state_q, state_d;
  logic [IDW-1:0]  ptr_q, ptr_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [31:0]     alu_a_q, alu_a_d, alu_b_q, alu_b_d;
  logic [2:0]      alu_gin_q, alu_gin_d;
  logic            rsp_valid_q, rsp_valid_d;
  logic [IDW-1:0]  rsp_id_q, rsp_id_d;
  logic [31:0]     rsp_sum_q, rsp_sum_d;
  logic            rsp_z_q, rsp_z_d, rsp_n_q, rsp_n_d, rsp_v_q, rsp_v_d;
  logic            rsp_err_q, rsp_err_d;

  logic [NREQ-1:0] pick_grant;
  logic [IDW-1:0]  pick_idx;
  logic            pick_any;
  logic [31:0]     win_a, win_b;
  logic [2:0]      win_gin;
  logic            accept;

  rr_pick #(.NREQ(NREQ), .IDW(IDW)) u_pick (
    .valid_i (req_valid),
    .ptr_i   (ptr_q),
    .grant_o (pick_grant),
    .idx_o   (pick_idx),
    .any_o   (pick_any)
  );

  always_comb begin
    win_a   = '0;
    win_b   = '0;
    win_gin = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (pick_idx == IDW'(i)) begin
        win_a   = req_a[i*32 +: 32];
        win_b   = req_b[i*32 +: 32];
        win_gin = req_gin[i*3 +: 3];
      end
    end
  end

  always_comb begin
    if (state_q == ST_IDLE && !reset) req_ready = pick_grant;
    else                              req_ready = '0;
  end

  assign accept = (state_q == ST_IDLE) && pick_any;

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    cnt_d       = cnt_q;
    alu_a_d     = alu_a_q;
    alu_b_d     = alu_b_q;
    alu_gin_d   = alu_gin_q;
    rsp_valid_d = rsp_valid_q;
    rsp_id_d    = rsp_id_q;
    rsp_sum_d   = rsp_sum_q;
    rsp_z_d     = rsp_z_q;
    rsp_n_d     = rsp_n_q;
    rsp_v_d     = rsp_v_q;
    rsp_err_d   = rsp_err_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          alu_a_d   = win_a;
          alu_b_d   = win_b;
          alu_gin_d = win_gin;
          rsp_id_d  = pick_idx;
          ptr_d     = (pick_idx == IDW'(NREQ-1)) ? '0 : pick_idx + IDW'(1);
          if (gin_legal(win_gin)) begin
            cnt_d   = CW'(ALU_WAIT-1);
            state_d = ST_SETTLE;
          end else begin
            // Error payload is staged now; rsp_valid follows one cycle later.
            rsp_sum_d = 32'd0;
            rsp_z_d   = 1'b0;
            rsp_n_d   = 1'b0;
            rsp_v_d   = 1'b0;
            rsp_err_d = 1'b1;
            state_d   = ST_RESP;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SETTLE: begin
        if (cnt_q == '0) begin
          rsp_sum_d   = alu_sum;
          rsp_z_d     = alu_zout;
          rsp_n_d     = alu_n;
          rsp_v_d     = alu_v;
          rsp_err_d   = 1'b0;
          rsp_valid_d = 1'b1;
          state_d     = ST_RESP;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      ST_RESP: begin
        if (!rsp_valid_q) begin
          rsp_valid_d = 1'b1;
        end else if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end else begin
          rsp_valid_d = 1'b1;
        end
      end
      default: begin
        state_d     = ST_IDLE;
        rsp_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      ptr_q       <= '0;
      cnt_q       <= '0;
      alu_a_q     <= 32'd0;
      alu_b_q     <= 32'd0;
      alu_gin_q   <= 3'b000;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      rsp_sum_q   <= 32'd0;
      rsp_z_q     <= 1'b0;
      rsp_n_q     <= 1'b0;
      rsp_v_q     <= 1'b0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      cnt_q       <= cnt_d;
      alu_a_q     <= alu_a_d;
      alu_b_q     <= alu_b_d;
      alu_gin_q   <= alu_gin_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
      rsp_sum_q   <= rsp_sum_d;
      rsp_z_q     <= rsp_z_d;
      rsp_n_q     <= rsp_n_d;
      rsp_v_q     <= rsp_v_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign alu_a     = alu_a_q;
  assign alu_b     = alu_b_q;
  assign alu_gin   = alu_gin_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_sum   = rsp_sum_q;
  assign rsp_z     = rsp_z_q;
  assign rsp_n     = rsp_n_q;
  assign rsp_v     = rsp_v_q;
  assign rsp_err   = rsp_err_q;
  assign busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_alu_share_ctrl.sv
// Bench for alu_share_ctrl: an environment ALU, a transaction-level model
// checked every cycle, and directed scenarios with literal expectations.
module tb_alu_share_ctrl;
  import alu_share_ctrl_pkg::*;

  localparam int NREQ = 4;
  localparam int IDW = 2;
  localparam int ALU_WAIT = 2;

  logic clk = 1'b0;
  logic reset;
  logic [NREQ-1:0] req_valid, req_ready;
  logic [NREQ*32-1:0] req_a, req_b;
  logic [NREQ*3-1:0] req_gin;
  logic [31:0] alu_a, alu_b, alu_sum, rsp_sum;
  logic [2:0] alu_gin;
  logic alu_zout, alu_n, alu_v, rsp_valid, rsp_ready, rsp_z, rsp_n, rsp_v, rsp_err, busy;
  logic [IDW-1:0] rsp_id;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;

  alu_share_ctrl #(.NREQ(NREQ), .IDW(IDW), .ALU_WAIT(ALU_WAIT)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_gin(req_gin),
    .alu_a(alu_a), .alu_b(alu_b), .alu_gin(alu_gin),
    .alu_sum(alu_sum), .alu_zout(alu_zout), .alu_n(alu_n), .alu_v(alu_v),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_sum(rsp_sum), .rsp_z(rsp_z), .rsp_n(rsp_n), .rsp_v(rsp_v),
    .rsp_err(rsp_err), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Reference ALU: {v, n, z, sum}
  function automatic logic [34:0] alu_f(input logic [31:0] a, input logic [31:0] b, input logic [2:0] g);
    logic [31:0] s;
    logic v;
    s = 32'd0;
    v = 1'b0;
    case (g)
      3'b010: begin s = a + b; v = (a[31] == b[31]) && (s[31] != a[31]); end
      3'b110: begin s = a - b; v = (a[31] != b[31]) && (s[31] != a[31]); end
      3'b111: s = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      3'b000: s = a & b;
      3'b001: s = a | b;
      default: s = 32'd0;
    endcase
    return {v, s[31], (s == 32'd0), s};
  endfunction

  function automatic bit legal(input logic [2:0] g);
    return (g == 3'b010) || (g == 3'b110) || (g == 3'b111) || (g == 3'b000) || (g == 3'b001);
  endfunction

  function automatic int pick(input logic [NREQ-1:0] v, input int p);
    for (int k = 0; k < NREQ; k++)
      if (v[(p + k) % NREQ]) return (p + k) % NREQ;
    return -1;
  endfunction

  always_comb {alu_v, alu_n, alu_zout, alu_sum} = alu_f(alu_a, alu_b, alu_gin);

  // Transaction-level model
  bit m_busy = 1'b0;
  int m_due = 0;
  int m_ptr = 0;
  logic [31:0] m_a = 32'd0, m_b = 32'd0, e_sum = 32'd0;
  logic [2:0] m_gin = 3'd0;
  logic e_z = 1'b0, e_n = 1'b0, e_v = 1'b0, e_err = 1'b0;
  int e_id = 0;

  always @(negedge clk) begin : model
    logic [NREQ-1:0] e_ready;
    logic [34:0] r;
    int w;
    bit e_valid;
    cyc++;
    if (reset) begin
      chk("rst_req_ready", 32'(req_ready), 32'd0);
      chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_alu_a", alu_a, 32'd0);
      chk("rst_alu_gin", 32'(alu_gin), 32'd0);
      chk("rst_rsp_sum", rsp_sum, 32'd0);
      m_busy = 1'b0; m_ptr = 0; m_a = 32'd0; m_b = 32'd0; m_gin = 3'd0;
    end else begin
      w = pick(req_valid, m_ptr);
      e_ready = '0;
      if (!m_busy && w >= 0) e_ready[w] = 1'b1;
      e_valid = m_busy && (cyc >= m_due);
      chk("req_ready", 32'(req_ready), 32'(e_ready));
      chk("busy", 32'(busy), 32'(m_busy));
      chk("rsp_valid", 32'(rsp_valid), 32'(e_valid));
      chk("alu_a", alu_a, m_a);
      chk("alu_b", alu_b, m_b);
      chk("alu_gin", 32'(alu_gin), 32'(m_gin));
      if (e_valid) begin
        chk("rsp_sum", rsp_sum, e_sum);
        chk("rsp_flags", {29'd0, rsp_z, rsp_n, rsp_v}, {29'd0, e_z, e_n, e_v});
        chk("rsp_err", 32'(rsp_err), 32'(e_err));
        chk("rsp_id", 32'(rsp_id), 32'(e_id));
      end
      if (!m_busy && w >= 0) begin
        m_a = req_a[w*32 +: 32];
        m_b = req_b[w*32 +: 32];
        m_gin = req_gin[w*3 +: 3];
        e_id = w;
        m_busy = 1'b1;
        m_ptr = (w + 1) % NREQ;
        if (legal(m_gin)) begin
          r = alu_f(m_a, m_b, m_gin);
          {e_v, e_n, e_z, e_sum} = r;
          e_err = 1'b0;
          m_due = cyc + ALU_WAIT + 1;
        end else begin
          {e_v, e_n, e_z, e_sum} = 35'd0;
          e_err = 1'b1;
          m_due = cyc + 2;
        end
      end else if (e_valid && rsp_ready) begin
        m_busy = 1'b0;
      end
    end
  end

  task automatic set_op(input int i, input logic [31:0] a, input logic [31:0] b, input logic [2:0] g);
    req_a[i*32 +: 32] = a;
    req_b[i*32 +: 32] = b;
    req_gin[i*3 +: 3] = g;
  endtask

  task automatic issue(input int i, input logic [31:0] a, input logic [31:0] b, input logic [2:0] g);
    @(posedge clk); #2;
    set_op(i, a, b, g);
    req_valid[i] = 1'b1;
  endtask

  task automatic wait_accept(input int i, output int c);
    bit ok;
    ok = 1'b0;
    c = 0;
    for (int t = 0; t < 40 && !ok; t++) begin
      @(negedge clk); #1;
      if (req_ready[i] && req_valid[i]) begin ok = 1'b1; c = cyc; end
    end
    if (!ok) chk("accept_timeout", 32'd0, 32'd1);
    @(posedge clk); #2;
    req_valid[i] = 1'b0;
  endtask

  task automatic wait_rsp(output int c);
    bit ok;
    ok = 1'b0;
    c = 0;
    for (int t = 0; t < 40 && !ok; t++) begin
      @(negedge clk); #1;
      if (rsp_valid) begin ok = 1'b1; c = cyc; end
    end
    if (!ok) chk("rsp_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int ca, cr, ng;
    int g_idx[5];
    int g_cyc[5];
    int exp_order[5];
    logic [31:0] cap_sum;
    logic [IDW-1:0] cap_id;
    exp_order = '{0, 1, 2, 3, 0};
    reset = 1'b1;
    req_valid = '1;
    req_a = '0; req_b = '0; req_gin = '0;
    rsp_ready = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    chk("reset_req_ready", 32'(req_ready), 32'd0);
    chk("reset_alu_gin", 32'(alu_gin), 32'd0);
    @(posedge clk); #2;
    reset = 1'b0;
    req_valid = '0;

    // Single ADD
    issue(0, 32'd5, 32'd7, GIN_ADD);
    wait_accept(0, ca);
    wait_rsp(cr);
    chk("add_latency", 32'(cr - ca), 32'd3);
    chk("add_sum", rsp_sum, 32'd12);
    chk("add_z", 32'(rsp_z), 32'd0);
    chk("add_id", 32'(rsp_id), 32'd0);
    chk("add_err", 32'(rsp_err), 32'd0);

    // SUB to zero
    issue(2, 32'h1234, 32'h1234, GIN_SUB);
    wait_accept(2, ca);
    wait_rsp(cr);
    chk("sub_sum", rsp_sum, 32'd0);
    chk("sub_z", 32'(rsp_z), 32'd1);
    chk("sub_id", 32'(rsp_id), 32'd2);

    // Illegal code
    issue(1, 32'hDEAD_BEEF, 32'h1, 3'b011);
    wait_accept(1, ca);
    wait_rsp(cr);
    chk("ill_latency", 32'(cr - ca), 32'd2);
    chk("ill_err", 32'(rsp_err), 32'd1);
    chk("ill_sum", rsp_sum, 32'd0);

    // AND from requester 3 leaves the pointer at 0
    issue(3, 32'hF0F0_1234, 32'h0FF0_FFFF, GIN_AND);
    wait_accept(3, ca);
    wait_rsp(cr);
    chk("and_sum", rsp_sum, 32'h00F0_1234);
    chk("and_id", 32'(rsp_id), 32'd3);

    // Round-robin with every requester valid
    @(posedge clk); #2;
    set_op(0, 32'h0000_00F0, 32'h0000_0F00, GIN_OR);
    set_op(1, 32'hFFFF_FFFF, 32'd1, GIN_SLT);
    set_op(2, 32'h7FFF_FFFF, 32'd1, GIN_ADD);
    set_op(3, 32'd3, 32'd5, GIN_SUB);
    req_valid = '1;
    ng = 0;
    for (int t = 0; t < 60 && ng < 5; t++) begin
      @(negedge clk); #1;
      if ((req_ready & req_valid) != '0) begin
        for (int i = 0; i < NREQ; i++) if (req_ready[i]) g_idx[ng] = i;
        g_cyc[ng] = cyc;
        ng++;
      end
    end
    @(posedge clk); #2;
    req_valid = '0;
    chk("rr_grants", 32'(ng), 32'd5);
    for (int k = 0; k < 5; k++) chk("rr_order", 32'(g_idx[k]), 32'(exp_order[k]));
    for (int k = 1; k < 5; k++) chk("rr_spacing", 32'(g_cyc[k] - g_cyc[k-1]), 32'(ALU_WAIT + 2));
    repeat (6) @(posedge clk);

    // Backpressure; pointer is 1, so requester 1 wins, then 2
    #2;
    rsp_ready = 1'b0;
    req_valid = '1;
    wait_rsp(cr);
    cap_sum = rsp_sum;
    cap_id = rsp_id;
    chk("bp_id", 32'(rsp_id), 32'd1);
    chk("bp_sum", rsp_sum, 32'd1);
    for (int t = 0; t < 5; t++) begin
      @(negedge clk); #1;
      chk("bp_valid_held", 32'(rsp_valid), 32'd1);
      chk("bp_sum_stable", rsp_sum, cap_sum);
      chk("bp_id_stable", 32'(rsp_id), 32'(cap_id));
      chk("bp_no_ready", 32'(req_ready), 32'd0);
    end
    @(posedge clk); #2;
    rsp_ready = 1'b1;
    @(negedge clk); #1;
    chk("bp_release_ready", 32'(req_ready), 32'd0);
    @(negedge clk); #1;
    chk("bp_next_grant", 32'(req_ready), 32'b0100);
    @(posedge clk); #2;
    req_valid = '0;
    repeat (6) @(posedge clk);

    // Reset in the middle of SETTLE; pointer was 3 and would pick 3 next
    issue(1, 32'd100, 32'd200, GIN_ADD);
    wait_accept(1, ca);
    reset = 1'b1;
    #1;
    chk("rstm_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rstm_busy", 32'(busy), 32'd0);
    chk("rstm_alu_a", alu_a, 32'd0);
    chk("rstm_req_ready", 32'(req_ready), 32'd0);
    req_valid = 4'b1001;
    @(posedge clk); #2;
    reset = 1'b0;
    @(negedge clk); #1;
    chk("rstm_first_grant", 32'(req_ready), 32'b0001);
    @(posedge clk); #2;
    req_valid = '0;
    repeat (6) @(posedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
